// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame geometry, 16 MHz timing constants, frame CRC.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package dshot_pkg;

   localparam int DSHOT_FRAME_BITS    = 16;
   localparam int DSHOT_THROTTLE_BITS = 11;

   // DShot150 at 16 MHz (6.67 us bit, 5.0 us / 2.5 us high times)
   localparam int DSHOT150_BIT_CYCLES = 107;
   localparam int DSHOT150_T1H_CYCLES = 80;
   localparam int DSHOT150_T0H_CYCLES = 40;

   // DShot300 at 16 MHz (3.33 us bit, 2.5 us / 1.25 us high times)
   localparam int DSHOT300_BIT_CYCLES = 53;
   localparam int DSHOT300_T1H_CYCLES = 40;
   localparam int DSHOT300_T0H_CYCLES = 20;

   // Minimum inter-frame low time (20 us at 16 MHz)
   localparam int DSHOT_GAP_CYCLES = 320;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_BIT,
      ST_GAP
   } dshot_state_t;

   // XOR of the three nibbles of {throttle, telemetry}
   function automatic logic [3:0] dshot_crc(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction

endpackage

// File: rtl/dshot_bit_cell.sv
// Generates one pulse-width-coded DShot bit per go strobe; pulses bit_end on its last cycle.
// Latency: pin is registered, so it rises one cycle after the first counting cycle.
// Backpressure: none; go may be re-issued on the bit_end cycle for gapless bits.
module dshot_bit_cell #(
   parameter int BIT_CYCLES = 107,
   parameter int T1H_CYCLES = 80,
   parameter int T0H_CYCLES = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic bit_val,
   output logic pin,
   output logic bit_end
);

   localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] T1H  = CW'(T1H_CYCLES);
   localparam logic [CW-1:0] T0H  = CW'(T0H_CYCLES);

   logic          active;
   logic [CW-1:0] cyc;
   logic [CW-1:0] high_len;

   assign high_len = bit_val ? T1H : T0H;
   assign bit_end  = active && (cyc == LAST);

   // Bit period counter: go (re)starts a period which runs 0..LAST and then stops
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cyc    <= '0;
      end else if (go) begin
         active <= 1'b1;
         cyc    <= '0;
      end else if (bit_end) begin
         active <= 1'b0;
         cyc    <= '0;
      end else if (active) begin
         cyc    <= cyc + CW'(1);
      end
   end

   // Registered pin: high during the first high_len cycles of each active period
   always_ff @(posedge clk) begin
      if (rst) pin <= 1'b0;
      else     pin <= active && (cyc < high_len);
   end

endmodule

// File: rtl/dshot_tx.sv
// DShot transmitter: latches throttle/telemetry, appends CRC, serialises 16 bits MSB-first.
// Latency: accept at edge N, first pin rise at N+2, frame_done GAP_CYCLES after the last bit.
// Backpressure: ready low from acceptance until the gap completes; start while busy is dropped.
module dshot_tx
   import dshot_pkg::*;
#(
   parameter int BIT_CYCLES = DSHOT150_BIT_CYCLES,
   parameter int T1H_CYCLES = DSHOT150_T1H_CYCLES,
   parameter int T0H_CYCLES = DSHOT150_T0H_CYCLES,
   parameter int GAP_CYCLES = DSHOT_GAP_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [DSHOT_THROTTLE_BITS-1:0] throttle,
   input  logic                           telemetry,
   output logic                           ready,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           dshotPin
);

   localparam int            FB       = DSHOT_FRAME_BITS;
   localparam int            IW       = $clog2(FB);
   localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
         T1H_CYCLES < BIT_CYCLES && GAP_CYCLES >= 1)) begin : g_bad_params
      $error("dshot_tx: timing parameters out of range");
   end

   dshot_state_t                   state, state_n;
   logic [DSHOT_THROTTLE_BITS-1:0] thr_q;
   logic                           tel_q;
   logic [FB-1:0]                  shreg;
   logic [IW-1:0]                  bit_idx;
   logic [GW-1:0]                  gap_cnt;
   logic                           gap_last;
   logic                           go;
   logic                           bit_end;

   assign gap_last = (gap_cnt == GAP_LAST);
   assign ready    = (state == ST_IDLE);
   assign busy     = ~ready;

   dshot_bit_cell #(
      .BIT_CYCLES (BIT_CYCLES),
      .T1H_CYCLES (T1H_CYCLES),
      .T0H_CYCLES (T0H_CYCLES)
   ) u_bit_cell (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .bit_val (shreg[FB-1]),
      .pin     (dshotPin),
      .bit_end (bit_end)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state and per-bit go strobe (first bit from LOAD, later bits on bit_end)
   always_comb begin
      state_n = state;
      go      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_n = ST_LOAD;
         ST_LOAD: begin
            go      = 1'b1;
            state_n = ST_BIT;
         end
         ST_BIT: begin
            if (bit_end) begin
               if (bit_idx == '0) state_n = ST_GAP;
               else               go      = 1'b1;
            end
         end
         ST_GAP: if (gap_last) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Input latch, frame shift register, bit index, gap counter and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q      <= '0;
         tel_q      <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         gap_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  thr_q <= throttle;
                  tel_q <= telemetry;
               end
            end
            ST_LOAD: begin
               shreg   <= {thr_q, tel_q, dshot_crc({thr_q, tel_q})};
               bit_idx <= IW'(FB - 1);
               gap_cnt <= '0;
            end
            ST_BIT: begin
               if (bit_end) begin
                  shreg <= {shreg[FB-2:0], 1'b0};
                  if (bit_idx != '0) bit_idx <= bit_idx - IW'(1);
               end
            end
            ST_GAP: begin
               if (gap_last) begin
                  gap_cnt    <= '0;
                  frame_done <= 1'b1;
               end else begin
                  gap_cnt    <= gap_cnt + GW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dshot_tx.sv
// Self-checking bench for dshot_tx: pulse-width decoding of the pin against a frame model.
// Latency: sample i of a capture is the value just after edge N+i (N = acceptance edge).
// Backpressure: start is only raised once ready is seen high, except for deliberate pokes.
module tb_dshot_tx;

   localparam int BITC  = 107;
   localparam int GAPC  = 320;
   // First rise at N+2, 16 bit periods, so the frame occupies samples 2..1713
   localparam int FEND  = 2 + 16 * BITC;        // 1714: first sample after the frame
   localparam int FDONE = FEND - 1 + GAPC;      // 2033: frame_done sample
   localparam int NCAP  = 4200;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] throttle;
   logic        telemetry;
   logic        ready, busy, frame_done, dshotPin;

   int tests = 0;
   int fails = 0;

   logic pin_s [0:NCAP-1];
   logic fd_s  [0:NCAP-1];
   logic rdy_s [0:NCAP-1];
   logic bsy_s [0:NCAP-1];

   typedef struct {
      logic [10:0] thr;
      logic        tel;
      logic [15:0] exp;
      int          poke;
   } vec_t;

   vec_t tbl [4];

   dshot_tx dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .throttle   (throttle),
      .telemetry  (telemetry),
      .ready      (ready),
      .busy       (busy),
      .frame_done (frame_done),
      .dshotPin   (dshotPin)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Reference frame: {throttle, telemetry} followed by the XOR of its three nibbles
   function automatic logic [15:0] model_frame(input int thr, input int tel);
      int v, crc;
      v   = thr * 2 + tel;
      crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
      return 16'(v * 16 + crc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input int limit);
      int k;
      k = 0;
      while (ready !== 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("ready_wait", ready, 1'b1);
   endtask

   task automatic send(input logic [10:0] thr, input logic tel);
      wait_ready(3000);
      throttle  = thr;
      telemetry = tel;
      start     = 1'b1;
   endtask

   // Record n samples; start drops at drop_at, is pulsed for one cycle at poke_at,
   // and throttle is overwritten at chg_at.
   task automatic capture(input int n, input int drop_at, input int poke_at,
                          input int chg_at, input logic [10:0] chg_thr);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pin_s[i] = dshotPin;
         fd_s[i]  = frame_done;
         rdy_s[i] = ready;
         bsy_s[i] = busy;
         if (i == drop_at) start = 1'b0;
         if (i == poke_at) start = 1'b1;
         else if (i == poke_at + 1) start = 1'b0;
         if (i == chg_at) begin
            throttle  = chg_thr;
            telemetry = ~telemetry;
         end
      end
   endtask

   // Decode one frame whose acceptance edge is at sample index base
   task automatic analyse(input int base, input logic [15:0] exp, input string tag);
      int          first, bad, ones, r, gap_hi, fd_at, fd_cnt;
      logic [15:0] got;
      first = -1;
      for (int i = base; i < base + 200; i++)
         if (first < 0 && pin_s[i] === 1'b1) first = i;
      chk({tag, "_first_rise"}, first - base, 2);
      bad = 0;
      got = '0;
      for (int b = 0; b < 16; b++) begin
         r    = base + 2 + BITC * b;
         ones = 0;
         while (ones < BITC && pin_s[r + ones] === 1'b1) ones++;
         for (int j = ones; j < BITC; j++)
            if (pin_s[r + j] !== 1'b0) bad++;
         if (ones == 80)      got = {got[14:0], 1'b1};
         else if (ones == 40) got = {got[14:0], 1'b0};
         else                 bad++;
      end
      chk({tag, "_frame"}, got, exp);
      chk({tag, "_pulse_timing_errors"}, bad, 0);
      gap_hi = 0;
      for (int i = base + FEND; i <= base + FDONE; i++)
         if (pin_s[i] !== 1'b0) gap_hi++;
      chk({tag, "_gap_high_samples"}, gap_hi, 0);
      fd_at  = -1;
      fd_cnt = 0;
      for (int i = base + 1; i <= base + FDONE + 1; i++)
         if (fd_s[i] === 1'b1) begin
            fd_cnt++;
            if (fd_at < 0) fd_at = i;
         end
      chk({tag, "_done_offset"}, fd_at - base, FDONE);
      chk({tag, "_done_count"}, fd_cnt, 1);
      chk({tag, "_busy_at_accept"}, {rdy_s[base], bsy_s[base]}, 2'b01);
      chk({tag, "_ready_before_done"}, rdy_s[base + FDONE - 1], 1'b0);
      chk({tag, "_ready_busy_at_done"}, {rdy_s[base + FDONE], bsy_s[base + FDONE]}, 2'b10);
   endtask

   initial begin
      int          hi, fdc, rdy_bad, low_run;
      logic [10:0] rthr;
      logic        rtel;

      tbl[0] = '{thr: 11'd0,    tel: 1'b0, exp: 16'h0000, poke: -10};
      tbl[1] = '{thr: 11'd1046, tel: 1'b0, exp: 16'h82C6, poke: 1000};
      tbl[2] = '{thr: 11'd48,   tel: 1'b0, exp: 16'h0606, poke: 1900};
      tbl[3] = '{thr: 11'd2047, tel: 1'b1, exp: 16'hFFFF, poke: 5};

      rst       = 1'b1;
      start     = 1'b0;
      throttle  = '0;
      telemetry = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pin", dshotPin, 1'b0);
      chk("reset_ready", ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", frame_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Directed frames; a stray start pulse mid-frame must be ignored
      for (int t = 0; t < 4; t++) begin
         send(tbl[t].thr, tbl[t].tel);
         capture(FDONE + 6, 0, tbl[t].poke, 0, 11'(t * 333 + 7));
         analyse(0, tbl[t].exp, $sformatf("vec%0d", t));
      end

      // Randomised frames against the arithmetic model
      for (int t = 0; t < 4; t++) begin
         rthr = 11'($urandom_range(0, 2047));
         rtel = 1'($urandom_range(0, 1));
         send(rthr, rtel);
         capture(FDONE + 6, 0, $urandom_range(10, 1700), 0, 11'($urandom));
         analyse(0, model_frame(int'(rthr), int'(rtel)), $sformatf("rnd%0d", t));
      end

      // start held high: back-to-back frames, throttle changed mid-frame 1
      send(11'd1046, 1'b0);
      capture(NCAP, 4000, -10, 900, 11'd48);
      analyse(0, 16'h82C6, "b2b_first");
      // second frame is accepted at edge N+FDONE+1 (one IDLE cycle after frame_done)
      analyse(FDONE + 1, model_frame(48, 1), "b2b_second");
      low_run = 0;
      while (FEND + low_run < NCAP && pin_s[FEND + low_run] === 1'b0) low_run++;
      // 320 gap cycles + 1 IDLE cycle + 1 LOAD cycle before the next registered rise
      chk("b2b_low_between_frames", low_run, GAPC + 2);

      // Reset while bit 7 is high; start on the same edge is ignored
      telemetry = 1'b0;
      send(11'd1046, 1'b0);
      capture(2 + 7 * BITC + 10, 0, -10, -10, 11'd0);
      chk("prerst_pin_high", dshotPin, 1'b1);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("midrst_pin", dshotPin, 1'b0);
      chk("midrst_ready", ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", frame_done, 1'b0);
      rst   = 1'b0;
      start = 1'b0;
      hi      = 0;
      fdc     = 0;
      rdy_bad = 0;
      for (int i = 0; i < 2100; i++) begin
         @(negedge clk);
         if (dshotPin !== 1'b0) hi++;
         if (frame_done !== 1'b0) fdc++;
         if (ready !== 1'b1) rdy_bad++;
      end
      chk("postrst_pin_activity", hi, 0);
      chk("postrst_frame_done", fdc, 0);
      chk("postrst_not_ready", rdy_bad, 0);
      send(11'd1046, 1'b0);
      capture(FDONE + 6, 0, -10, 0, 11'd3);
      analyse(0, 16'h82C6, "postrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
